// File: rtl/trim_seq_gen.sv
// Serial trim-code generator: shifts a CODE_W-bit code out on DOUT/ENCLK and strobes LOAD.
// Optional macro TRIM_PARITY_EN appends an even-parity bit after the data bits.
module trim_seq_gen #(
  parameter int CODE_W    = 12,
  parameter int DIV_MAX   = 25000000,
  parameter int DIV_W     = 25,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              CLK50,
  input  logic              RST,
  input  logic              START,
  input  logic              MODE,
  input  logic [CODE_W-1:0] CODE_IN,
  input  logic [CODE_W-1:0] CODE_END,
  input  logic [CODE_W-1:0] STEP,
  output logic              DOUT,
  output logic              ENCLK,
  output logic              LOAD,
  output logic [CODE_W-1:0] TRIMCODE,
  output logic              BUSY,
  output logic              DONE
);

`ifdef TRIM_PARITY_EN
  localparam int NBITS = CODE_W + 1;
`else
  localparam int NBITS = CODE_W;
`endif
  localparam int CNT_W = $clog2(NBITS + 1);

  typedef enum logic [2:0] {IDLE, PREP, SH_LO, SH_HI, LATCH, FIN} state_t;

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  logic [NBITS-1:0]  shift_reg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CODE_W-1:0] cur_code, code_end_r, step_r;
  logic              mode_r;
  logic [CODE_W:0]   nxt_sum;
  logic [CODE_W-1:0] code_sel;
  logic              sweep_end, next_bit;
  logic              dout_nxt, enclk_nxt, load_nxt, busy_nxt, done_nxt;

  // Frame image in shift order; parity sits where it leaves the register last.
  function automatic logic [NBITS-1:0] load_image(input logic [CODE_W-1:0] code);
`ifdef TRIM_PARITY_EN
    return MSB_FIRST ? {code, ^code} : {^code, code};
`else
    return code;
`endif
  endfunction

  assign tick      = (div_cnt == DIV_W'(DIV_MAX));
  assign nxt_sum   = {1'b0, cur_code} + {1'b0, step_r};
  // Carry out of CODE_W bits means the sweep would wrap; treat it as past the end.
  assign sweep_end = mode_r | nxt_sum[CODE_W] | (nxt_sum[CODE_W-1:0] > code_end_r);
  assign next_bit  = MSB_FIRST ? shift_reg[NBITS-1] : shift_reg[0];
  assign code_sel  = (state == IDLE) ? CODE_IN : nxt_sum[CODE_W-1:0];

  always_ff @(posedge CLK50) begin
    if (RST) div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else div_cnt <= div_cnt + 1'b1;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (START) state_nxt = PREP;
      PREP:    state_nxt = SH_LO;
      SH_LO:   state_nxt = SH_HI;
      SH_HI:   state_nxt = (bit_cnt == CNT_W'(NBITS)) ? LATCH : SH_LO;
      LATCH:   state_nxt = sweep_end ? FIN : (START ? PREP : IDLE);
      FIN:     if (!START) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs take the values belonging to the state being entered.
  always_comb begin
    dout_nxt  = 1'b0;
    enclk_nxt = 1'b0;
    load_nxt  = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state_nxt)
      PREP:  busy_nxt = 1'b1;
      SH_LO: begin busy_nxt = 1'b1; dout_nxt = next_bit; end
      SH_HI: begin busy_nxt = 1'b1; dout_nxt = DOUT; enclk_nxt = 1'b1; end
      LATCH: begin busy_nxt = 1'b1; load_nxt = 1'b1; end
      FIN:   done_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK50) begin
    if (RST) begin
      // NOTE: the shift register is cleared on reset too, so an aborted frame leaves no residue.
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      cur_code   <= '0;
      code_end_r <= '0;
      step_r     <= '0;
      mode_r     <= 1'b0;
      DOUT       <= 1'b0;
      ENCLK      <= 1'b0;
      LOAD       <= 1'b0;
      TRIMCODE   <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else if (tick) begin
      // NOTE: non-blocking so every register sees pre-tick values of the others.
      state <= state_nxt;
      DOUT  <= dout_nxt;
      ENCLK <= enclk_nxt;
      LOAD  <= load_nxt;
      BUSY  <= busy_nxt;
      DONE  <= done_nxt;
      if (state == IDLE && START) begin
        mode_r     <= MODE;
        code_end_r <= CODE_END;
        step_r     <= (STEP == '0) ? CODE_W'(1) : STEP;
      end
      if (state_nxt == PREP) begin
        cur_code  <= code_sel;
        TRIMCODE  <= code_sel;
        shift_reg <= load_image(code_sel);
        bit_cnt   <= '0;
      end
      if (state_nxt == SH_HI) begin
        shift_reg <= MSB_FIRST ? {shift_reg[NBITS-2:0], 1'b0} : {1'b0, shift_reg[NBITS-1:1]};
        bit_cnt   <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_trim_seq_gen.sv
// Directed bench for trim_seq_gen: LSB-first and MSB-first instances share stimulus.
// Expected bit patterns follow TRIM_PARITY_EN when the macro is defined.
module tb_trim_seq_gen;

  localparam int CODE_W  = 4;
  localparam int DIV_MAX = 1;
  localparam int DIV_W   = 2;
`ifdef TRIM_PARITY_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, mode = 1'b0;
  logic [CODE_W-1:0] code_in = '0, code_end = '0, step = '0;
  logic dout_a, enclk_a, load_a, busy_a, done_a;
  logic dout_b, enclk_b, load_b, busy_b, done_b;
  logic [CODE_W-1:0] trim_a, trim_b;

  int checks = 0, errors = 0;
  int b_n, b_nb, b_ld, b_done;

  // Monitor state
  logic enclk_a_q = 1'b0, enclk_b_q = 1'b0, load_a_q = 1'b0, done_a_q = 1'b0;
  int n_a = 0, n_b = 0, n_ld = 0, n_done = 0;
  logic [15:0] seq_a = '0, seq_b = '0;
  logic [31:0] ld_codes = '0;
  logic [15:0] mask;

  always #5 clk = ~clk;

  trim_seq_gen #(.CODE_W(CODE_W), .DIV_MAX(DIV_MAX), .DIV_W(DIV_W), .MSB_FIRST(1'b0)) dut_lsb (
    .CLK50(clk), .RST(rst), .START(start), .MODE(mode), .CODE_IN(code_in),
    .CODE_END(code_end), .STEP(step), .DOUT(dout_a), .ENCLK(enclk_a), .LOAD(load_a),
    .TRIMCODE(trim_a), .BUSY(busy_a), .DONE(done_a));

  trim_seq_gen #(.CODE_W(CODE_W), .DIV_MAX(DIV_MAX), .DIV_W(DIV_W), .MSB_FIRST(1'b1)) dut_msb (
    .CLK50(clk), .RST(rst), .START(start), .MODE(mode), .CODE_IN(code_in),
    .CODE_END(code_end), .STEP(step), .DOUT(dout_b), .ENCLK(enclk_b), .LOAD(load_b),
    .TRIMCODE(trim_b), .BUSY(busy_b), .DONE(done_b));

  // Outputs move on posedge only, so sampling on negedge is race-free.
  always @(negedge clk) begin
    enclk_a_q <= enclk_a;
    enclk_b_q <= enclk_b;
    load_a_q  <= load_a;
    done_a_q  <= done_a;
    if (enclk_a && !enclk_a_q) begin
      n_a   <= n_a + 1;
      seq_a <= {seq_a[14:0], dout_a};
    end
    if (enclk_b && !enclk_b_q) begin
      n_b   <= n_b + 1;
      seq_b <= {seq_b[14:0], dout_b};
    end
    if (load_a && !load_a_q) begin
      n_ld     <= n_ld + 1;
      ld_codes <= {ld_codes[27:0], trim_a};
    end
    if (done_a && !done_a_q) n_done <= n_done + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snapshot();
    b_n = n_a; b_nb = n_b; b_ld = n_ld; b_done = n_done;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!done_a && k < 400) begin
      @(negedge clk);
      k++;
    end
    check({tag, " done"}, 32'(done_a), 32'd1);
    @(negedge clk);
  endtask

  task automatic release_start(input string tag);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check({tag, " done cleared"}, 32'(done_a), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " dout"},  32'(dout_a),  32'd0);
    check({tag, " enclk"}, 32'(enclk_a), 32'd0);
    check({tag, " load"},  32'(load_a),  32'd0);
    check({tag, " trim"},  32'(trim_a),  32'd0);
    check({tag, " busy"},  32'(busy_a),  32'd0);
    check({tag, " done"},  32'(done_a),  32'd0);
  endtask

  initial begin
    mask = (16'h1 << NB) - 16'h1;
    repeat (4) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single code 3, both bit orders
    mode = 1'b1; code_in = 4'h3; start = 1'b1;
    snapshot();
    wait_done("single3");
    check("single3 lsb pulses", 32'(n_a - b_n), 32'(NB));
    check("single3 msb pulses", 32'(n_b - b_nb), 32'(NB));
`ifdef TRIM_PARITY_EN
    check("single3 lsb bits", 32'(seq_a & mask), 32'b11000);
    check("single3 msb bits", 32'(seq_b & mask), 32'b00110);
`else
    check("single3 lsb bits", 32'(seq_a & mask), 32'b1100);
    check("single3 msb bits", 32'(seq_b & mask), 32'b0011);
`endif
    check("single3 loads", 32'(n_ld - b_ld), 32'd1);
    check("single3 trimcode", 32'(trim_a), 32'h3);
    check("single3 busy", 32'(busy_a), 32'd0);
    release_start("single3");

    // Single code 7: odd parity content
    code_in = 4'h7; start = 1'b1;
    snapshot();
    wait_done("single7");
    check("single7 pulses", 32'(n_a - b_n), 32'(NB));
`ifdef TRIM_PARITY_EN
    check("single7 lsb bits", 32'(seq_a & mask), 32'b11101);
    check("single7 msb bits", 32'(seq_b & mask), 32'b01111);
`else
    check("single7 lsb bits", 32'(seq_a & mask), 32'b1110);
    check("single7 msb bits", 32'(seq_b & mask), 32'b0111);
`endif
    check("single7 loads", 32'(n_ld - b_ld), 32'd1);
    release_start("single7");

    // Sweep 0..5 step 2
    mode = 1'b0; code_in = 4'd0; code_end = 4'd5; step = 4'd2; start = 1'b1;
    snapshot();
    wait_done("sweep025");
    check("sweep025 loads", 32'(n_ld - b_ld), 32'd3);
    check("sweep025 codes", 32'(ld_codes[11:0]), 32'h024);
    check("sweep025 pulses", 32'(n_a - b_n), 32'(3 * NB));
    check("sweep025 trimcode", 32'(trim_a), 32'h4);
    release_start("sweep025");

    // Step 0 behaves as step 1
    code_end = 4'd2; step = 4'd0; start = 1'b1;
    snapshot();
    wait_done("step0");
    check("step0 loads", 32'(n_ld - b_ld), 32'd3);
    check("step0 codes", 32'(ld_codes[11:0]), 32'h012);
    release_start("step0");

    // Wrap detection: 14 + 3 overflows
    code_in = 4'd14; code_end = 4'd15; step = 4'd3; start = 1'b1;
    snapshot();
    wait_done("wrap3");
    check("wrap3 loads", 32'(n_ld - b_ld), 32'd1);
    check("wrap3 code", 32'(ld_codes[3:0]), 32'hE);
    release_start("wrap3");

    // End at all-ones with step 1: 14, 15, then stop
    step = 4'd1; start = 1'b1;
    snapshot();
    wait_done("wrap1");
    check("wrap1 loads", 32'(n_ld - b_ld), 32'd2);
    check("wrap1 codes", 32'(ld_codes[7:0]), 32'hEF);
    check("wrap1 trimcode", 32'(trim_a), 32'hF);
    release_start("wrap1");

    // Start beyond end: one frame only
    code_in = 4'd5; code_end = 4'd2; start = 1'b1;
    snapshot();
    wait_done("start_gt_end");
    check("start_gt_end loads", 32'(n_ld - b_ld), 32'd1);
    check("start_gt_end code", 32'(ld_codes[3:0]), 32'h5);
    release_start("start_gt_end");

    // Reset during the third SH_HI
    mode = 1'b1; code_in = 4'h3; start = 1'b1;
    snapshot();
    begin
      int k = 0;
      while ((n_a - b_n) < 3 && k < 200) begin
        @(negedge clk);
        k++;
      end
    end
    check("rst3 reached", 32'(n_a - b_n), 32'd3);
    check("rst3 enclk high", 32'(enclk_a), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("rst3");
    start = 1'b0;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rst3 no load", 32'(n_ld - b_ld), 32'd0);
    check("rst3 idle busy", 32'(busy_a), 32'd0);

    // START dropped during the second frame of a sweep
    mode = 1'b0; code_in = 4'd0; code_end = 4'd15; step = 4'd1; start = 1'b1;
    snapshot();
    begin
      int k = 0;
      while ((n_a - b_n) < NB + 2 && k < 200) begin
        @(negedge clk);
        k++;
      end
    end
    start = 1'b0;
    repeat (60) @(negedge clk);
    check("abort loads", 32'(n_ld - b_ld), 32'd2);
    check("abort codes", 32'(ld_codes[7:0]), 32'h01);
    check("abort busy", 32'(busy_a), 32'd0);
    check("abort done", 32'(done_a), 32'd0);
    check("abort no done pulse", 32'(n_done - b_done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
